avalon_mem_responder: RTL and testbench

//  Avalon-MM slave memory model for the multicycle MIPS core. Answers the

---
 rtl/mips_bus_pkg.sv | 22 ++
 rtl/avalon_mem_responder_if.sv | 20 ++
 rtl/mem_lfsr16.sv | 19 +
 rtl/avalon_mem_responder.sv | 151 +++++++++++++++
 tb/tb_avalon_mem_responder.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/mips_bus_pkg.sv
// Shared bus definitions for the MIPS core memory port and its responder.
package mips_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2
    } mem_state_t;

    localparam int          WORD_BYTES   = 4;
    localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;

    // Word number of a byte address relative to a region base; the two
    // low address bits select a byte inside the word and are discarded.
    function automatic logic [29:0] word_of(input logic [31:0] byte_addr,
                                            input logic [31:0] base);
        logic [31:0] offset;
        offset = byte_addr - base;
        return offset[31:2];
    endfunction

endpackage

// File: rtl/avalon_mem_responder_if.sv
// Avalon-MM bus between the core's memory port (master) and the responder (slave).
interface avalon_mem_responder_if;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        waitrequest;

    modport master (
        output address, read, write, byteenable, writedata,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, read, write, byteenable, writedata,
        output readdata, waitrequest
    );
endinterface

// File: rtl/mem_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) used to jitter the responder's
// wait-state count. Only present in RESPONDER_RANDOM_WAIT_EN builds.
module mem_lfsr16 (
    input  logic        clk,
    input  logic        Rst,
    input  logic        advance,
    output logic [15:0] value
);

    // Shift once per accepted request; reset reloads the fixed seed.
    always_ff @(posedge clk) begin
        if (Rst) begin
            value <= 16'hACE1;
        end else if (advance) begin
            value <= {value[14:0], value[15] ^ value[13] ^ value[12] ^ value[10]};
        end
    end

endmodule

// File: rtl/avalon_mem_responder.sv
// Avalon-MM slave memory with waitrequest back-pressure, byte-lane writes and
// WAIT_CYCLES wait states per access. Define RESPONDER_RANDOM_WAIT_EN to add
// 0..3 pseudo-random extra wait cycles per request (LFSR driven).
module avalon_mem_responder
    import mips_bus_pkg::*;
#(
    parameter int          MEM_WORDS   = 1024,
    parameter logic [31:0] BASE_ADDR   = RESET_VECTOR,
    parameter int          WAIT_CYCLES = 1,
    parameter              INIT_FILE   = ""
) (
    input  logic                  clk,
    input  logic                  Rst,
    avalon_mem_responder_if.slave bus
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    // The image named by INIT_FILE is attached through the FPGA flow's
    // memory-initialisation mechanism, not loaded by this RTL.
    localparam bit init_file_unused = (INIT_FILE != "");

    logic [31:0]      mem [MEM_WORDS];
    mem_state_t       state, state_next;
    logic [4:0]       cnt, cnt_next;
    logic [4:0]       wait_load;
    logic [IDX_W-1:0] idx, acc_idx;
    logic [31:0]      rd_data;
    logic             req, stall, load_rd;

    assign req = bus.read | bus.write;
    assign idx = IDX_W'(word_of(bus.address, BASE_ADDR));

`ifdef RESPONDER_RANDOM_WAIT_EN
    logic [15:0] lfsr_value;
    logic        lfsr_advance;
    logic        lfsr_unused;

    assign lfsr_advance = (state == IDLE) && req;
    assign lfsr_unused  = ^lfsr_value[15:2];
    assign wait_load    = 5'(WAIT_CYCLES) + {3'b000, lfsr_value[1:0]};

    mem_lfsr16 u_lfsr (
        .clk     (clk),
        .Rst     (Rst),
        .advance (lfsr_advance),
        .value   (lfsr_value)
    );
`else
    assign wait_load = 5'(WAIT_CYCLES);
`endif

    // Next-state, wait counter and stall decode for the access handshake.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        load_rd    = 1'b0;
        stall      = req && (state != ACCESS);
        case (state)
            IDLE: begin
                if (req) begin
                    cnt_next = wait_load;
                    if (wait_load != 5'd0) begin
                        state_next = WAIT;
                    end else begin
                        state_next = ACCESS;
                        load_rd    = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    state_next = IDLE;
                end else if (cnt == 5'd1) begin
                    state_next = ACCESS;
                    load_rd    = 1'b1;
                end else begin
                    cnt_next = cnt - 5'd1;
                end
            end
            ACCESS:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Control registers and the read-data output register.
    always_ff @(posedge clk) begin
        if (Rst) begin
            state   <= IDLE;
            cnt     <= 5'd0;
            rd_data <= 32'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (load_rd) begin
                rd_data <= mem[idx];
            end
        end
    end

    // Latch the word index on entry to ACCESS; the write commits to it.
    always_ff @(posedge clk) begin
        if (load_rd) begin
            acc_idx <= idx;
        end
    end

    // Byte-lane write at the end of the ACCESS cycle; a reset drops it.
    always_ff @(posedge clk) begin
        if (!Rst && (state == ACCESS) && bus.write) begin
            for (int b = 0; b < WORD_BYTES; b++) begin
                if (bus.byteenable[b]) begin
                    mem[acc_idx][8*b +: 8] <= bus.writedata[8*b +: 8];
                end
            end
        end
    end

    assign bus.readdata    = rd_data;
    assign bus.waitrequest = stall;

`ifndef SYNTHESIS
    logic [31:0] prev_address, prev_writedata;
    logic [3:0]  prev_byteenable;
    logic        prev_read, prev_write, prev_stall;

    // Remember the bus as seen at the previous edge for the hold check.
    always_ff @(posedge clk) begin
        prev_address    <= bus.address;
        prev_writedata  <= bus.writedata;
        prev_byteenable <= bus.byteenable;
        prev_read       <= bus.read;
        prev_write      <= bus.write;
        prev_stall      <= stall;
    end

    // Flag simultaneous read/write and inputs that move while stalled.
    always @(posedge clk) begin
        if (!Rst) begin
            assert (!(bus.read && bus.write))
                else $error("avalon_mem_responder: read and write asserted together");
            if (prev_stall === 1'b1) begin
                assert ({bus.address, bus.writedata, bus.byteenable, bus.read, bus.write} ==
                        {prev_address, prev_writedata, prev_byteenable, prev_read, prev_write})
                    else $error("avalon_mem_responder: inputs changed while waitrequest high");
            end
        end
    end
`endif

endmodule

// File: tb/tb_avalon_mem_responder.sv
// Directed bench for avalon_mem_responder: two instances (WAIT_CYCLES=1 and 0),
// scoreboard queues for expected wait counts and read data.
module tb_avalon_mem_responder;

    localparam int          W_A   = 1;
    localparam int          W_B   = 0;
    localparam int          WORDS = 16;
    localparam logic [31:0] BASE  = 32'hBFC00000;

    logic clk = 1'b0;
    logic Rst = 1'b1;
    always #5 clk = ~clk;

    avalon_mem_responder_if bus_a();
    avalon_mem_responder_if bus_b();

    avalon_mem_responder #(.MEM_WORDS(WORDS), .BASE_ADDR(BASE), .WAIT_CYCLES(W_A), .INIT_FILE(""))
        dut_a (.clk(clk), .Rst(Rst), .bus(bus_a));
    avalon_mem_responder #(.MEM_WORDS(WORDS), .BASE_ADDR(BASE), .WAIT_CYCLES(W_B), .INIT_FILE(""))
        dut_b (.clk(clk), .Rst(Rst), .bus(bus_b));

    int          n_checks = 0;
    int          n_fail   = 0;
    int          wait_q[$];
    logic [31:0] data_q[$];

`ifdef RESPONDER_RANDOM_WAIT_EN
    logic [15:0] lfsr_a, lfsr_b;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction
`endif

    task automatic reseed();
`ifdef RESPONDER_RANDOM_WAIT_EN
        lfsr_a = 16'hACE1;
        lfsr_b = 16'hACE1;
`endif
    endtask

    // Expected number of waitrequest-high cycles for the next request.
    task automatic next_wait(input bit on_b, output int w);
`ifdef RESPONDER_RANDOM_WAIT_EN
        if (on_b) begin
            w = W_B + 1 + int'(lfsr_b[1:0]);
            lfsr_b = lfsr_step(lfsr_b);
        end else begin
            w = W_A + 1 + int'(lfsr_a[1:0]);
            lfsr_a = lfsr_step(lfsr_a);
        end
`else
        w = (on_b ? W_B : W_A) + 1;
`endif
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit on_b, input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be);
        if (on_b) begin
            bus_b.read = rd; bus_b.write = wr; bus_b.address = a;
            bus_b.writedata = d; bus_b.byteenable = be;
        end else begin
            bus_a.read = rd; bus_a.write = wr; bus_a.address = a;
            bus_a.writedata = d; bus_a.byteenable = be;
        end
    endtask

    function automatic logic stalled(input bit on_b);
        return on_b ? bus_b.waitrequest : bus_a.waitrequest;
    endfunction

    function automatic logic [31:0] rdata(input bit on_b);
        return on_b ? bus_b.readdata : bus_a.readdata;
    endfunction

    // One complete transfer; called at posedge+1 and returns at posedge+1
    // with the bus released, so consecutive calls are back-to-back.
    task automatic bus_access(input bit on_b, input bit is_wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] be,
                              input logic [31:0] exp_rd, input string tag, output int waits);
        int exp_w;
        bit done;
        next_wait(on_b, exp_w);
        wait_q.push_back(exp_w);
        if (!is_wr) data_q.push_back(exp_rd);
        drive(on_b, !is_wr, is_wr, addr, wdata, be);
        waits = 0;
        done  = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            if (stalled(on_b) === 1'b1) waits++;
            else done = 1'b1;
        end
        check_int({tag, "_done"}, int'(done), 1);
        check_int({tag, "_waits"}, waits, wait_q.pop_front());
        if (!is_wr) check32({tag, "_data"}, rdata(on_b), data_q.pop_front());
        @(posedge clk);
        #1;
        drive(on_b, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
    endtask

    function automatic logic [31:0] pattern(input int i);
        return 32'h5A000000 ^ (32'h01010101 * 32'(i + 1));
    endfunction

    initial begin
        int w;
        int wmin, wmax;
        reseed();
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
        Rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 Rst = 1'b0;

        // Reset state: idle bus, cleared read data
        @(negedge clk);
        check32("rst_rdata_a", bus_a.readdata, 32'd0);
        check32("rst_wreq_a", {31'd0, bus_a.waitrequest}, 32'd0);
        check32("rst_rdata_b", bus_b.readdata, 32'd0);
        check32("rst_wreq_b", {31'd0, bus_b.waitrequest}, 32'd0);
        @(posedge clk);
        #1;

        // Read of the reset vector after preloading it
        bus_access(1'b0, 1'b1, BASE, 32'h24020005, 4'hF, 32'd0, "t1_preload", w);
        bus_access(1'b0, 1'b0, BASE, 32'd0, 4'h0, 32'h24020005, "t1_read", w);
        repeat (2) @(negedge clk);
        check32("t1_hold", bus_a.readdata, 32'h24020005);
        @(posedge clk);
        #1;

        // Partial lane write
        bus_access(1'b0, 1'b1, BASE + 32'h10, 32'h11223344, 4'hF, 32'd0, "t2_full", w);
        bus_access(1'b0, 1'b1, BASE + 32'h10, 32'hDEADBEEF, 4'b0101, 32'd0, "t2_lanes", w);
        bus_access(1'b0, 1'b0, BASE + 32'h10, 32'd0, 4'h0, 32'h11AD33EF, "t2_read", w);

        // Write with no lanes enabled leaves memory unchanged
        bus_access(1'b0, 1'b1, BASE + 32'h10, 32'hFFFFFFFF, 4'h0, 32'd0, "be0_write", w);
        bus_access(1'b0, 1'b0, BASE + 32'h10, 32'd0, 4'h0, 32'h11AD33EF, "be0_read", w);

        // Address wraps modulo the memory depth
        bus_access(1'b0, 1'b1, BASE + 32'(4 * WORDS), 32'hCAFEF00D, 4'hF, 32'd0, "t4_wrap_wr", w);
        bus_access(1'b0, 1'b0, BASE, 32'd0, 4'h0, 32'hCAFEF00D, "t4_wrap_rd", w);

        // Reset in the middle of a write's wait phase
        drive(1'b0, 1'b0, 1'b1, BASE + 32'h10, 32'h55555555, 4'hF);
        @(negedge clk);
        check32("t5_stall_idle", {31'd0, bus_a.waitrequest}, 32'd1);
        @(negedge clk);
        check32("t5_stall_wait", {31'd0, bus_a.waitrequest}, 32'd1);
        Rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
        @(posedge clk);
        #1 Rst = 1'b0;
        reseed();
        @(negedge clk);
        check32("t5_rdata", bus_a.readdata, 32'd0);
        check32("t5_wreq", {31'd0, bus_a.waitrequest}, 32'd0);
        @(posedge clk);
        #1;
        bus_access(1'b0, 1'b0, BASE + 32'h10, 32'd0, 4'h0, 32'h11AD33EF, "t5_unchanged", w);

        // Zero wait states, back-to-back reads
        bus_access(1'b1, 1'b1, BASE, 32'hA0A0A0A0, 4'hF, 32'd0, "t3_wr0", w);
        bus_access(1'b1, 1'b1, BASE + 32'h4, 32'hB4B4B4B4, 4'hF, 32'd0, "t3_wr1", w);
        bus_access(1'b1, 1'b0, BASE, 32'd0, 4'h0, 32'hA0A0A0A0, "t3_rd0", w);
        bus_access(1'b1, 1'b0, BASE + 32'h4, 32'd0, 4'h0, 32'hB4B4B4B4, "t3_rd1", w);
        bus_access(1'b1, 1'b0, BASE, 32'd0, 4'h0, 32'hA0A0A0A0, "t3_rd2", w);

`ifdef RESPONDER_RANDOM_WAIT_EN
        // Randomised wait lengths: span and repeatability after reset
        for (int i = 0; i < WORDS; i++)
            bus_access(1'b0, 1'b1, BASE + 32'(4 * i), pattern(i), 4'hF, 32'd0, "t6_fill", w);
        wmin = 99;
        wmax = 0;
        for (int i = 0; i < 100; i++) begin
            bus_access(1'b0, 1'b0, BASE + 32'(4 * (i % WORDS)), 32'd0, 4'h0,
                       pattern(i % WORDS), "t6_read", w);
            if (w < wmin) wmin = w;
            if (w > wmax) wmax = w;
        end
        check_int("t6_min_wait", wmin, W_A + 1);
        check_int("t6_max_wait", wmax, W_A + 4);
        Rst = 1'b1;
        @(posedge clk);
        #1 Rst = 1'b0;
        reseed();
        for (int i = 0; i < 8; i++)
            bus_access(1'b0, 1'b0, BASE + 32'(4 * i), 32'd0, 4'h0, pattern(i), "t6_repeat", w);
`else
        wmin = 0;
        wmax = 0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
